fetch_stage: RTL

Instruction-fetch stage of the RV32I 5-stage pipeline. It holds the program counter, drives the instruction-memory address, and owns the IF/ID pipeline register. It obeys the hazard unit's `PCWrite`/`ifidWrite` hold requests and the EX-stage branch redirect. It also supplies `ifid_rs1`/`ifid_rs2` back to the hazard unit and keeps a fetched-instruction performance counter.

---
 rtl/fetch_stage.sv | 73 +++++++
 1 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: program counter, imem address, IF/ID register
// and fetched-instruction counter, honouring hazard-unit holds and EX redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        ifidWrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic [4:0]  ifid_rs1,
    output logic [4:0]  ifid_rs2,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ifid_pc;
    logic [XLEN-1:0] r_ifid_instr;
    logic            r_ifid_valid;
    logic [XLEN-1:0] r_fetch_count;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_pc_plus4    = r_pc + XLEN'(4);
    assign w_redirect_pc = {branch_target[XLEN-1:2], 2'b00};

    // A redirect flushes IF/ID even under a stall: the held instruction is wrong-path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_ifid_pc     <= '0;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_valid  <= 1'b0;
            r_fetch_count <= '0;
        end else if (branch_taken) begin
            r_pc          <= w_redirect_pc;
            r_ifid_pc     <= r_pc;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_valid  <= 1'b0;
        end else begin
            if (PCWrite) begin
                r_pc <= w_pc_plus4;
            end
            if (ifidWrite) begin
                r_ifid_pc     <= r_pc;
                r_ifid_instr  <= imem_rdata;
                r_ifid_valid  <= 1'b1;
                r_fetch_count <= r_fetch_count + XLEN'(1);
            end
        end
    end

    assign imem_addr   = r_pc;
    assign ifid_pc     = r_ifid_pc;
    assign ifid_instr  = r_ifid_instr;
    assign ifid_valid  = r_ifid_valid;
    assign fetch_count = r_fetch_count;

    // Register-field taps for the hazard unit; NOP decodes to x0/x0.
    assign ifid_rs1 = r_ifid_instr[19:15];
    assign ifid_rs2 = r_ifid_instr[24:20];

endmodule
